trace_buffer: RTL and testbench
===============================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024: trace RAM entries, a power of two.
REQ-002 The block SHALL have parameter CAP_LIMIT, default 1000: entries captured before automatic stop, 1 to DEPTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cap_en, input, 1 bit: the CPU retired an instruction this cycle; capture pc/inst.
REQ-006 The block SHALL have port pc, input, 32 bits: program counter of the retiring instruction.
REQ-007 The block SHALL have port inst, input, 32 bits: instruction word of the retiring instruction.
REQ-008 The block SHALL have port cap_stop, input, 1 bit: force end of capture.
REQ-009 The block SHALL have port clear, input, 1 bit: discard the trace and return to IDLE.
REQ-010 The block SHALL have port rd_req, input, 1 bit: request the next stored entry.
REQ-011 The block SHALL have port rd_valid, output, 1 bit: rd_pc/rd_inst hold a valid entry this cycle.
REQ-012 The block SHALL have port rd_pc, output, 32 bits: pc of the entry read out.
REQ-013 The block SHALL have port rd_inst, output, 32 bits: inst of the entry read out.
REQ-014 The block SHALL have port count, output, clog2(DEPTH)+1 bits: number of entries captured.
REQ-015 The block SHALL have port empty, output, 1 bit: every captured entry has been read (rd_ptr == count).
REQ-016 The block SHALL have port state, output, 2 bits: IDLE=0, CAPTURE=1, DONE=2.

Function
REQ-017 In IDLE, the first cycle with cap_en=1 SHALL write {pc,inst} to entry 0, set count=1 and enter CAPTURE.
REQ-018 In CAPTURE, each cycle with cap_en=1 SHALL write {pc,inst} at address count and increment count.
- A cycle with cap_en=0 SHALL pause capture without a state change.
REQ-019 When an entry is written making count==CAP_LIMIT, state SHALL go to DONE on that same edge.
- No further writes SHALL occur; cap_en SHALL be ignored in DONE.
REQ-020 cap_stop=1 in IDLE or CAPTURE SHALL move state to DONE.
- If cap_en is also 1 in that cycle, that entry SHALL be written first (unless the limit is already reached).
REQ-021 rd_req SHALL be honoured only in DONE with empty=0.
- The entry at rd_ptr SHALL be presented on rd_pc/rd_inst with rd_valid=1 exactly one cycle after the rd_req cycle.
- rd_ptr SHALL increment.
REQ-022 rd_req in IDLE or CAPTURE, or with empty=1, SHALL be ignored.
- rd_valid SHALL be 0 the following cycle; rd_pc/rd_inst SHALL hold their previous values.
REQ-023 Back-to-back rd_req SHALL yield one entry per cycle in write order, with no gaps.
REQ-024 clear=1 SHALL, in any state, on the next edge:
- set state=IDLE, count=0, rd_ptr=0 and rd_valid=0;
- override every other input that cycle (no capture, no read).
REQ-025 RAM contents SHALL NOT be reset; only entries below count are ever read.
REQ-026 count SHALL never exceed CAP_LIMIT, and the write address SHALL never wrap.

Reset
REQ-027 While rst=1, regardless of clk, the block SHALL hold:
- state=IDLE, count=0, rd_ptr=0, empty=1;
- rd_valid=0, rd_pc=0, rd_inst=0.
REQ-028 rst asserted mid-capture or mid-readout SHALL abort the operation immediately.
- After release, the block SHALL behave as freshly reset.
REQ-029 The first capture SHALL occur on the first rising edge after rst deasserts with cap_en=1.

Verification
REQ-030 Basic capture and readout:
- Stimulus: reset; cap_en=1 for 3 cycles with (pc,inst) = (00400000,3c1d1001), (00400004,24080005), (00400008,01094020); cap_stop; 3 rd_req pulses.
- Response: count=3, state=DONE; rd_valid one cycle after each rd_req, with the three pairs in order; then empty=1.
REQ-031 Capture limit:
- Stimulus: CAP_LIMIT=4, cap_en=1 for 6 cycles.
- Response: count=4; state=DONE on the 4th write; entries 5 and 6 discarded.
REQ-032 Paused capture:
- Stimulus: cap_en pattern 1,0,1,1 with distinct pcs.
- Response: count=3, state CAPTURE throughout, stored pcs exclude the cap_en=0 cycle.
REQ-033 Simultaneous stop:
- Stimulus: cap_stop=1 and cap_en=1 in the same cycle with pc=00400010.
- Response: that entry is stored, count increments and state=DONE.
REQ-034 Ignored reads:
- Stimulus: rd_req during CAPTURE, then rd_req in DONE after all entries are read.
- Response: rd_valid stays 0 and rd_ptr is unchanged in both cases.
REQ-035 Reset and clear mid-operation:
- Stimulus: rst pulse asserted between clock edges during readout; later, clear asserted in DONE.
- Response: outputs go to reset values without waiting for a clock edge (rst); state=IDLE and count=0 on the next edge (clear).

Source files
------------

// File: rtl/trace_buffer.sv
// Instruction trace buffer: records {pc,inst} of retiring instructions into a RAM,
// then replays them in write order on request.
// Latency: capture writes on the cap_en edge; read data appears one cycle after rd_req.
// Backpressure: none; cap_en is dropped once DONE or at CAP_LIMIT, and ignored reads are dropped.
//
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   cap_en, pc, inst    - capture strobe with the retiring instruction's pc/inst
//   cap_stop            - force the end of capture (entry on the same cycle is still stored)
//   clear               - discard the trace and return to IDLE (beats every other input)
//   rd_req              - request the next stored entry (honoured only in DONE with data left)
//   rd_valid, rd_pc, rd_inst - read response, one cycle after an honoured rd_req
//   count               - number of captured entries
//   empty               - every captured entry has been read
//   state               - IDLE=0, CAPTURE=1, DONE=2
module trace_buffer #(
   parameter int DEPTH     = 1024,
   parameter int CAP_LIMIT = 1000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cap_en,
   input  logic [31:0]              pc,
   input  logic [31:0]              inst,
   input  logic                     cap_stop,
   input  logic                     clear,
   input  logic                     rd_req,
   output logic                     rd_valid,
   output logic [31:0]              rd_pc,
   output logic [31:0]              rd_inst,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic [1:0]               state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LIMIT = CW'(CAP_LIMIT);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic          rd_valid_q, rd_valid_d;
   logic          rd_seen_q, rd_seen_d;
   logic [63:0]   rd_word_q;

   logic          wr_en;
   logic          rd_en;
   logic          last_wr;
   logic          empty_w;

   // Trace storage; deliberately not reset, only entries below count are ever read.
   logic [63:0]   mem [DEPTH];

   assign empty_w = (rd_ptr_q == count_q);
   assign last_wr = wr_en && ((count_q + CW'(1)) == LIMIT);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cap_stop || last_wr) begin
                  state_d = ST_DONE;
               end else if (wr_en) begin
                  state_d = ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (cap_stop || last_wr) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FSM: output decode (write and read enables)
   // ------------------------------------------------------------------
   always_comb begin
      wr_en = 1'b0;
      rd_en = 1'b0;
      case (state_q)
         ST_IDLE, ST_CAPTURE: begin
            // The limit guard keeps the write address from ever wrapping.
            wr_en = cap_en && !clear && (count_q < LIMIT);
         end
         ST_DONE: begin
            rd_en = rd_req && !clear && !empty_w;
         end
         default: begin
            wr_en = 1'b0;
            rd_en = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Counters and read-response control
   // ------------------------------------------------------------------
   always_comb begin
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      rd_valid_d = rd_en;
      rd_seen_d  = rd_seen_q;
      if (clear) begin
         count_d  = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_en) begin
            count_d = count_q + CW'(1);
         end
         if (rd_en) begin
            rd_ptr_d  = rd_ptr_q + CW'(1);
            rd_seen_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         rd_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_seen_q  <= 1'b0;
      end else begin
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_valid_q <= rd_valid_d;
         rd_seen_q  <= rd_seen_d;
      end
   end

   // ------------------------------------------------------------------
   // RAM write port and synchronous read port (no reset so it maps to block RAM)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[count_q[AW-1:0]] <= {pc, inst};
      end
   end

   // rd_word_q only loads on an honoured read, so it naturally holds the last
   // entry when a request is ignored.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_word_q <= mem[rd_ptr_q[AW-1:0]];
      end
   end

   // rd_seen_q is async-reset, so the read data reads as zero during and after
   // reset until the first real read, without putting a reset on the RAM output.
   assign rd_pc    = rd_seen_q ? rd_word_q[63:32] : 32'd0;
   assign rd_inst  = rd_seen_q ? rd_word_q[31:0]  : 32'd0;
   assign rd_valid = rd_valid_q;
   assign count    = count_q;
   assign empty    = empty_w;
   assign state    = state_q;

endmodule

// File: tb/tb_trace_buffer.sv
module tb_trace_buffer;

   localparam int DEPTH = 8;
   localparam int CAP   = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cap_en = 1'b0;
   logic          cap_stop = 1'b0;
   logic          clear = 1'b0;
   logic          rd_req = 1'b0;
   logic [31:0]   pc = '0;
   logic [31:0]   inst = '0;
   logic          rd_valid;
   logic [31:0]   rd_pc;
   logic [31:0]   rd_inst;
   logic [CW-1:0] count;
   logic          empty;
   logic [1:0]    state;

   int total = 0;
   int bad   = 0;

   // Scoreboard: expected read responses, and the last data seen on the read port.
   logic [63:0] exp_q[$];
   logic [63:0] last_rd = '0;

   // Reference model: the trace as a list, a read index and a state number.
   logic [63:0] trace[$];
   int m_rd_ptr = 0;
   int m_state  = 0;

   trace_buffer #(.DEPTH(DEPTH), .CAP_LIMIT(CAP)) dut (
      .clk      (clk),
      .rst      (rst),
      .cap_en   (cap_en),
      .pc       (pc),
      .inst     (inst),
      .cap_stop (cap_stop),
      .clear    (clear),
      .rd_req   (rd_req),
      .rd_valid (rd_valid),
      .rd_pc    (rd_pc),
      .rd_inst  (rd_inst),
      .count    (count),
      .empty    (empty),
      .state    (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      trace.delete();
      m_rd_ptr = 0;
      m_state  = 0;
   endtask

   task automatic model_step(input logic ce, input logic [31:0] p, input logic [31:0] i,
                             input logic stp, input logic rr, input logic clr);
      if (clr) begin
         model_reset();
         return;
      end
      if (m_state == 2) begin
         if (rr && m_rd_ptr < trace.size()) begin
            exp_q.push_back(trace[m_rd_ptr]);
            m_rd_ptr++;
         end
      end else begin
         if (ce && trace.size() < CAP) trace.push_back({p, i});
         if (stp || trace.size() == CAP) m_state = 2;
         else if (ce) m_state = 1;
      end
   endtask

   task automatic zero_inputs();
      cap_en = 1'b0; cap_stop = 1'b0; clear = 1'b0; rd_req = 1'b0;
      pc = '0; inst = '0;
   endtask

   // One clock of stimulus: drive after the falling edge, check after the rising edge.
   task automatic step(input logic ce, input logic [31:0] p, input logic [31:0] i,
                       input logic stp, input logic rr, input logic clr);
      @(negedge clk);
      #1;
      cap_en = ce; pc = p; inst = i; cap_stop = stp; rd_req = rr; clear = clr;
      model_step(ce, p, i, stp, rr, clr);
      @(posedge clk);
      #1;
      chk("state", 64'(state), 64'(m_state));
      chk("count", 64'(count), 64'(trace.size()));
      chk("empty", 64'(empty), 64'(m_rd_ptr == trace.size()));
      zero_inputs();
   endtask

   task automatic idle();
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd();
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"},    64'(state),    64'd0);
      chk({tag, "_count"},    64'(count),    64'd0);
      chk({tag, "_empty"},    64'(empty),    64'd1);
      chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
      chk({tag, "_rd_pc"},    64'(rd_pc),    64'd0);
      chk({tag, "_rd_inst"},  64'(rd_inst),  64'd0);
   endtask

   // Asserts rst between edges (caller is just after a rising edge) and checks
   // the outputs settle without any clock edge.
   task automatic async_rst_now();
      #2;
      rst = 1'b1;
      zero_inputs();
      #1;
      check_reset_outputs("async_rst");
      exp_q.delete();
      last_rd = '0;
      model_reset();
      @(posedge clk);
      #1;
      check_reset_outputs("rst_held");
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: pops the scoreboard whenever a response is due and otherwise
   // checks that the read port is quiet and holding its data.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("rd_valid", 64'(rd_valid), 64'd1);
            chk("rd_data", {rd_pc, rd_inst}, e);
            last_rd = e;
         end else begin
            chk("rd_quiet", 64'(rd_valid), 64'd0);
            chk("rd_hold", {rd_pc, rd_inst}, last_rd);
         end
      end
   end

   initial begin
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      #1;
      rst = 1'b0;

      // Basic capture, stop and readout.
      step(1'b1, 32'h00400000, 32'h3c1d1001, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00400004, 32'h24080005, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00400008, 32'h01094020, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("basic_count", 64'(count), 64'd3);
      chk("basic_state", 64'(state), 64'd2);
      rd(); rd(); rd();
      idle();
      chk("basic_empty", 64'(empty), 64'd1);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

      // Capture limit: six writes offered, only four kept.
      for (int k = 0; k < 6; k++)
         step(1'b1, 32'h00401000 + 32'(4 * k), 32'hA0000000 + 32'(k), 1'b0, 1'b0, 1'b0);
      chk("limit_count", 64'(count), 64'd4);
      chk("limit_state", 64'(state), 64'd2);
      for (int k = 0; k < 6; k++) rd();   // last two fall on empty and are ignored
      idle();
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

      // Paused capture, plus a read attempted during CAPTURE.
      step(1'b1, 32'h00402000, 32'h11111111, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h00402004, 32'h22222222, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00402008, 32'h33333333, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0040200c, 32'h44444444, 1'b0, 1'b0, 1'b0);
      chk("pause_count", 64'(count), 64'd3);
      chk("pause_state", 64'(state), 64'd1);
      rd();
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      rd(); rd(); rd();
      idle();
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

      // Simultaneous stop and capture, then reset mid-readout.
      step(1'b1, 32'h0040000c, 32'h55555555, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00400010, 32'h66666666, 1'b1, 1'b0, 1'b0);
      chk("stop_count", 64'(count), 64'd2);
      chk("stop_state", 64'(state), 64'd2);
      rd();
      chk("pre_rst_valid", 64'(rd_valid), 64'd1);
      async_rst_now();

      // First capture straight after reset release, then clear in DONE.
      step(1'b1, 32'h00403000, 32'h77777777, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      rd();
      step(1'b1, 32'h00403004, 32'h88888888, 1'b0, 1'b1, 1'b1);
      chk("clear_state", 64'(state), 64'd0);
      chk("clear_count", 64'(count), 64'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 9) < 7, $urandom, $urandom,
              $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 29) == 0);
      end
      idle();
      idle();
      chk("drain", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
